// File: rtl/hazard_fwd_unit.sv
// Hazard detection and forwarding control: shadow EX/MEM destination records drive stall and mux selects.
// Optional stall_cnt performance counter is enabled by defining HAZARD_PERF_EN.
module hazard_fwd_unit #(
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_branch,
    input  logic              id_regwrite,
    input  logic              id_memtoreg,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a_ex,
    output logic [1:0]        fwd_b_ex,
    output logic              fwd_a_id,
    output logic              fwd_b_id
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic              regwrite;
        logic              memtoreg;
        logic [REG_AW-1:0] rd;
    } rec_t;

    // The WB record is not kept: the register file is write-before-read, and the
    // MEM/WB forward for EX is decided one cycle earlier from the MEM record.
    rec_t       ex_q, ex_d, mem_q;
    logic [1:0] fwd_a_ex_q, fwd_a_ex_d;
    logic [1:0] fwd_b_ex_q, fwd_b_ex_d;

    logic ex_a, ex_b, mem_a, mem_b;
    logic haz_a, haz_b, issue;

    function automatic logic writes(input rec_t rec, input logic [REG_AW-1:0] r);
        return rec.valid && rec.regwrite && (rec.rd == r) && (r != '0);
    endfunction

    always_comb begin
        ex_a  = writes(ex_q, id_rs);
        ex_b  = writes(ex_q, id_rt);
        mem_a = writes(mem_q, id_rs);
        mem_b = writes(mem_q, id_rt);

        // Loads in EX block everyone; branches also wait on any EX result and on loads in MEM.
        haz_a = id_use_rs && ((ex_a && (ex_q.memtoreg || id_branch)) ||
                              (id_branch && mem_a && mem_q.memtoreg));
        haz_b = id_use_rt && ((ex_b && (ex_q.memtoreg || id_branch)) ||
                              (id_branch && mem_b && mem_q.memtoreg));
        stall = id_valid && !flush && (haz_a || haz_b);

        fwd_a_id = id_branch && mem_a && !mem_q.memtoreg;
        fwd_b_id = id_branch && mem_b && !mem_q.memtoreg;

        issue = id_valid && !flush && !stall;

        ex_d = '0;
        fwd_a_ex_d = 2'b00;
        fwd_b_ex_d = 2'b00;
        if (issue) begin
            ex_d.valid    = 1'b1;
            ex_d.regwrite = id_regwrite;
            ex_d.memtoreg = id_memtoreg;
            ex_d.rd       = id_rd;
            fwd_a_ex_d    = ex_a ? 2'b01 : (mem_a ? 2'b10 : 2'b00);
            fwd_b_ex_d    = ex_b ? 2'b01 : (mem_b ? 2'b10 : 2'b00);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q       <= '0;
            mem_q      <= '0;
            fwd_a_ex_q <= 2'b00;
            fwd_b_ex_q <= 2'b00;
        end else begin
            ex_q       <= ex_d;
            mem_q      <= ex_q;
            fwd_a_ex_q <= fwd_a_ex_d;
            fwd_b_ex_q <= fwd_b_ex_d;
        end
    end

    assign fwd_a_ex = fwd_a_ex_q;
    assign fwd_b_ex = fwd_b_ex_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed test-plan sequences, random traffic and a mid-stall reset.
// Also checks stall_cnt when HAZARD_PERF_EN is defined.
module tb_hazard_fwd_unit;

    typedef struct packed {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       useRs;
        logic       useRt;
        logic       branch;
        logic       regwrite;
        logic       memtoreg;
        logic [4:0] rd;
    } instr_t;

    typedef struct packed {
        logic       valid;
        logic       regwrite;
        logic       memtoreg;
        logic [4:0] rd;
    } rec_t;

    typedef struct packed {
        logic        stall;
        logic        faId;
        logic        fbId;
        logic [1:0]  faEx;
        logic [1:0]  fbEx;
        logic [31:0] cnt;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       idValid = 1'b0;
    logic [4:0] idRs = '0;
    logic [4:0] idRt = '0;
    logic       idUseRs = 1'b0;
    logic       idUseRt = 1'b0;
    logic       idBranch = 1'b0;
    logic       idRegwrite = 1'b0;
    logic       idMemtoreg = 1'b0;
    logic [4:0] idRd = '0;
    logic       flush = 1'b0;
    logic       stall;
    logic [1:0] fwdAEx, fwdBEx;
    logic       fwdAId, fwdBId;
`ifdef HAZARD_PERF_EN
    logic [31:0] stallCnt;
`endif

    int nCompared = 0;
    int nMismatched = 0;
    exp_t expQ[$];

    // Reference model: the instructions sitting in EX and MEM, plus the forwarding
    // choice each EX instruction was given while it was still in ID.
    rec_t        mEx = '0, mMem = '0, nEx = '0;
    logic [1:0]  mFa = '0, mFb = '0, nFa = '0, nFb = '0;
    logic [31:0] mCnt = '0;
    bit          pendStall = 0;
    bit          lastStall = 0;

    hazard_fwd_unit #(.REG_AW(5)) dut (
        .clk(clk),
        .rst(rst),
        .id_valid(idValid),
        .id_rs(idRs),
        .id_rt(idRt),
        .id_use_rs(idUseRs),
        .id_use_rt(idUseRt),
        .id_branch(idBranch),
        .id_regwrite(idRegwrite),
        .id_memtoreg(idMemtoreg),
        .id_rd(idRd),
        .flush(flush),
        .stall(stall),
        .fwd_a_ex(fwdAEx),
        .fwd_b_ex(fwdBEx),
        .fwd_a_id(fwdAId),
        .fwd_b_id(fwdBId)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt(stallCnt)
`endif
    );

    // Free-running pipeline clock.
    initial forever #5 clk = ~clk;

    function automatic bit writes(input rec_t rc, input logic [4:0] r);
        return rc.valid && rc.regwrite && rc.rd == r && r != 5'd0;
    endfunction

    function automatic bit hazard(input instr_t s, input logic [4:0] r);
        if (writes(mEx, r) && mEx.memtoreg) return 1;
        if (s.branch && writes(mEx, r)) return 1;
        if (s.branch && writes(mMem, r) && mMem.memtoreg) return 1;
        return 0;
    endfunction

    function automatic logic [1:0] srcFor(input logic [4:0] r);
        if (writes(mEx, r)) return 2'b01;
        if (writes(mMem, r)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic instr_t mk(input bit v, input int rs, input int rt, input bit ur, input bit ut,
                                  input bit br, input bit rw, input bit mt, input int rd);
        instr_t s;
        s.valid = v;
        s.rs = 5'(rs);
        s.rt = 5'(rt);
        s.useRs = ur;
        s.useRt = ut;
        s.branch = br;
        s.regwrite = rw;
        s.memtoreg = mt;
        s.rd = 5'(rd);
        return s;
    endfunction

    function automatic instr_t alu(input int rd, input int rs, input int rt);
        return mk(1, rs, rt, 1, 1, 0, 1, 0, rd);
    endfunction

    function automatic instr_t load(input int rd, input int base);
        return mk(1, base, rd, 1, 0, 0, 1, 1, rd);
    endfunction

    function automatic instr_t branch(input int rs, input int rt);
        return mk(1, rs, rt, 1, 1, 1, 0, 0, 0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One ID cycle: advance the model across the clock edge, drive the ID inputs
    // and queue what the DUT must show during this cycle.
    task automatic applyStimulus(input instr_t s, input bit fl);
        exp_t e;
        bit   st;
        @(posedge clk);
        #1;
        mMem = mEx;
        mEx  = nEx;
        mFa  = nFa;
        mFb  = nFb;
        mCnt = mCnt + (pendStall ? 32'd1 : 32'd0);

        idValid = s.valid;
        idRs = s.rs;
        idRt = s.rt;
        idUseRs = s.useRs;
        idUseRt = s.useRt;
        idBranch = s.branch;
        idRegwrite = s.regwrite;
        idMemtoreg = s.memtoreg;
        idRd = s.rd;
        flush = fl;

        st = s.valid && !fl && ((s.useRs && hazard(s, s.rs)) || (s.useRt && hazard(s, s.rt)));
        e.stall = st;
        e.faId = s.branch && writes(mMem, s.rs) && !mMem.memtoreg;
        e.fbId = s.branch && writes(mMem, s.rt) && !mMem.memtoreg;
        e.faEx = mFa;
        e.fbEx = mFb;
        e.cnt = mCnt;
        expQ.push_back(e);

        if (s.valid && !fl && !st) begin
            nEx = '{1'b1, s.regwrite, s.memtoreg, s.rd};
            nFa = srcFor(s.rs);
            nFb = srcFor(s.rt);
        end else begin
            nEx = '0;
            nFa = 2'b00;
            nFb = 2'b00;
        end
        pendStall = st;
        lastStall = st;
    endtask

    // Upstream behaviour: hold the instruction in ID until it is no longer stalled.
    task automatic issue(input instr_t s);
        int tries = 0;
        do begin
            applyStimulus(s, 0);
            tries++;
        end while (lastStall && tries < 4);
        if (lastStall) begin
            nMismatched++;
            $display("[TB] FAIL issue_bound: instruction still stalled after %0d cycles", tries);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus('0, 0);
    endtask

    // Monitor: every cycle the DUT presents its outputs, pop one expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("stall", 32'(stall), 32'(e.stall));
                checkOutput("fwd_a_id", 32'(fwdAId), 32'(e.faId));
                checkOutput("fwd_b_id", 32'(fwdBId), 32'(e.fbId));
                checkOutput("fwd_a_ex", 32'(fwdAEx), 32'(e.faEx));
                checkOutput("fwd_b_ex", 32'(fwdBEx), 32'(e.fbEx));
`ifdef HAZARD_PERF_EN
                checkOutput("stall_cnt", stallCnt, e.cnt);
`endif
            end
        end
    end

    // Stimulus: reset, test-plan sequences, random traffic, then reset during a load-use stall.
    initial begin
        instr_t s;
        #3;
        checkOutput("reset_stall", 32'(stall), 32'd0);
        checkOutput("reset_fwd_a_ex", 32'(fwdAEx), 32'd0);
        checkOutput("reset_fwd_b_ex", 32'(fwdBEx), 32'd0);
        checkOutput("reset_fwd_a_id", 32'(fwdAId), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        issue(alu(3, 1, 2));   issue(alu(8, 3, 1));   idle(3);
        issue(load(4, 1));     issue(alu(9, 4, 2));   idle(3);
        issue(load(5, 1));     issue(branch(5, 0));   idle(3);
        issue(alu(6, 1, 2));   issue(branch(6, 2));   idle(3);
        issue(alu(0, 1, 2));   issue(branch(0, 0));   issue(alu(9, 0, 0)); idle(3);
        issue(alu(7, 1, 2));   issue(alu(7, 2, 1));   issue(alu(9, 7, 7)); idle(3);
        issue(load(4, 1));     applyStimulus(alu(9, 4, 2), 1); idle(3);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                applyStimulus('0, 0);
            end else begin
                s = mk($urandom_range(0, 7) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 3));
                if ($urandom_range(0, 9) == 0) applyStimulus(s, 1);
                else issue(s);
            end
        end
        idle(3);

        issue(alu(2, 1, 1));
        issue(load(4, 2));
        applyStimulus(alu(9, 4, 1), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("midstall_reset_stall", 32'(stall), 32'd0);
        checkOutput("midstall_reset_fwd_a_ex", 32'(fwdAEx), 32'd0);
        checkOutput("midstall_reset_fwd_b_ex", 32'(fwdBEx), 32'd0);
`ifdef HAZARD_PERF_EN
        checkOutput("midstall_reset_stall_cnt", stallCnt, 32'd0);
`endif
        idValid = 1'b0; idUseRs = 1'b0; idUseRt = 1'b0; idBranch = 1'b0;
        idRegwrite = 1'b0; idMemtoreg = 1'b0; flush = 1'b0;
        mEx = '0; mMem = '0; nEx = '0;
        mFa = '0; mFb = '0; nFa = '0; nFb = '0;
        mCnt = '0; pendStall = 0;
        @(posedge clk);
        #1 rst = 1'b0;

        issue(load(4, 1)); issue(alu(9, 4, 2));
        issue(load(5, 1)); issue(branch(5, 0));
        idle(2);
        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
# hazard_fwd_unit

Hazard detection and forwarding-control stage of the 5-stage pipelined CPU. It tracks the destination registers of in-flight instructions in a shadow pipeline (EX, MEM, WB). From that state it drives the select inputs of the EX-stage operand `mux4` instances and the ID-stage branch-compare `mux2` instances. It also generates the load-use and branch-dependency stall that freezes PC and IF/ID.

## Interface
Parameters:
- `REG_AW`, 5, register index width.

Ports:
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_valid`  in  1  ID-stage instruction is real (not a bubble).
- `id_rs`, `id_rt`  in  REG_AW  ID source register indices.
- `id_use_rs`, `id_use_rt`  in  1  ID instruction actually reads rs / rt.
- `id_branch`  in  1  ID instruction is a branch compared in ID.
- `id_regwrite`  in  1  ID instruction writes a register.
- `id_memtoreg`  in  1  ID instruction is a load.
- `id_rd`  in  REG_AW  ID destination index (already muxed rt/rd).
- `flush`  in  1  kill the ID instruction this cycle.
- `stall`  out  1  combinational; hold PC and IF/ID, bubble into EX.
- `fwd_a_ex`, `fwd_b_ex`  out  2  registered; EX operand `mux4` select. 00 = ID/EX register value, 01 = EX/MEM ALU result, 10 = MEM/WB result; 11 is never driven.
- `fwd_a_id`, `fwd_b_id`  out  1  combinational; ID compare `mux2` select. 1 = EX/MEM ALU result.

## Operation
- Shadow records EX, MEM, WB each hold {valid, regwrite, memtoreg, rd}. Every cycle they shift: ID→EX, EX→MEM, MEM→WB.
- A record "writes r" when valid & regwrite & rd == r & r != 0. Register 0 never forwards or stalls.
- Register file is write-before-read, so WB-stage writes need no forwarding into ID.
- Stall conditions, evaluated only when id_valid & !flush, per used source r:
  - EX record is a load writing r (load-use).
  - id_branch & EX record writes r (any type).
  - id_branch & MEM record is a load writing r.
- fwd_*_id = 1 when id_branch, the MEM record writes r, and that record is not a load; otherwise 0.
- EX forwarding is computed in ID and registered into the EX stage with the instruction:
  - 01 if the current EX record writes r (it will be in MEM next cycle).
  - else 10 if the current MEM record writes r.
  - else 00.
  - Nearer stage wins when both match.
- On stall: EX record loads a bubble (valid = 0); fwd_*_ex load 00; ID inputs are held by upstream.
- On flush: same as stall for the EX record and fwd_*_ex; stall is forced 0. Priority: rst > flush > stall.

## Timing
- Reset (async): all records invalid; fwd_*_ex = 00; perf counter = 0. With records invalid, stall and fwd_*_id evaluate to 0.
- fwd_*_ex latency: computed in cycle N (instruction in ID), visible in cycle N+1 (instruction in EX).
- stall and fwd_*_id: same-cycle combinational from state plus ID inputs.
- Stall durations:
  - Load-use: 1 cycle.
  - Branch on an ALU result in EX: 1 cycle, then fwd_id = 1.
  - Branch on a load in EX: 2 cycles.
- Reset mid-stall: stall drops immediately with reset; no residual bubble.

## Configuration
- `HAZARD_PERF_EN` defined: adds output `stall_cnt` (32 bits). It increments on every cycle stall = 1, wraps at 2^32−1 → 0, and resets to 0.
- `HAZARD_PERF_EN` undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- `add $3` in ID, then `sub` reading $3 in ID next cycle → stall = 0, fwd_a_ex = 01 in sub's EX cycle.
- `lw $4`, then `add` reading $4 → stall = 1 for exactly 1 cycle; add enters EX with fwd = 10.
- `lw $5`, then `beq $5,$0` → stall = 1 for 2 cycles; branch then resolves with fwd_a_id = 0 (value from regfile).
- `add $6`, then `beq $6` → 1 stall cycle, then fwd_a_id = 1. Destination $0 in any case → no stall, all fwd = 0.
- `add $7` twice in succession, then `sub` reading $7 → fwd = 01 (nearer wins). Flush asserted with a pending stall → stall = 0, EX bubble.
- Assert rst during a load-use stall → stall and fwd_*_ex = 0 immediately. With HAZARD_PERF_EN, stall_cnt counts 3 after the load-use, branch-on-load (2) sequence.
